axis_match_unpack: RTL and testbench

Receive-side decoder for the ORB matcher's AXI-Stream output. The matcher serializes each 40-bit match record as two consecutive 20-bit halves in `tdata[19:0]`, high half first, with `tdata[31:20]` carrying overlay colour. This block reassembles the halves into 40-bit records, suppresses idle (all-zero) records, and buffers the results in a FIFO for the PS-side register reader. It also keeps frame and record statistics.

---
 rtl/orb_match_pkg.sv | 22 ++
 rtl/match_fifo.sv | 62 ++++++
 rtl/axis_match_unpack.sv | 140 ++++++++++++++
 tb/tb_axis_match_unpack.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orb_match_pkg.sv
// Shared types for the ORB match record decoder.
// Record widths, phase encoding and the saturating counter helper.
package orb_match_pkg;

  localparam int MATCH_W = 40;
  localparam int HALF_W  = 20;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  typedef struct packed {
    logic               last;
    logic [MATCH_W-1:0] data;
  } match_rec_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/match_fifo.sv
// First-word-fall-through record FIFO.
// Head word is visible whenever the FIFO is non-empty.
module match_fifo
  import orb_match_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [MATCH_W:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [MATCH_W:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [MATCH_W:0] mem [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;
  logic             wr;
  logic             rd;

  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  assign wr    = wr_en & ~full;
  assign rd    = rd_en & ~empty;

  // Gate the head so stale memory never shows on an empty FIFO.
  assign rd_data = empty ? '0 : mem[rp_q];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        wp_q <= wp_q + 1'b1;
      end
      if (rd) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_match_unpack.sv
// Reassembles 20-bit AXI-Stream halves into 40-bit match records,
// drops idle records and buffers the rest for the PS reader.
module axis_match_unpack
  import orb_match_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_ZERO  = 1
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  input  logic [31:0]        s_axis_tdata,
  input  logic [3:0]         s_axis_tkeep,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [MATCH_W-1:0] m_match_data,
  output logic               m_match_last,
  output logic               m_match_valid,
  input  logic               m_match_ready,
  input  logic               clr,
  output logic [15:0]        rec_cnt,
  output logic [15:0]        skip_cnt,
  output logic               frame_irq,
  output logic               err_odd
);

  phase_t             ph_q;
  phase_t             ph_d;
  logic               rdy_q;
  logic [HALF_W-1:0]  hi_q;
  logic [MATCH_W-1:0] rec;
  match_rec_t         push_rec;
  match_rec_t         head;
  logic [MATCH_W:0]   head_bits;
  logic               hs;
  logic               keep_ok;
  logic               keep_rec;
  logic               push;
  logic               skip;
  logic               odd;
  logic               latch_hi;
  logic               full;
  logic               empty;
  logic               unused_colour;

  assign unused_colour = ^s_axis_tdata[31:HALF_W];

  // Full only gates the low half, so a held-off reader never loses data.
  assign s_axis_tready = rdy_q & ((ph_q == PH_HI) | ~full);
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign keep_ok       = s_axis_tkeep == 4'hf;
  assign rec           = {hi_q, s_axis_tdata[HALF_W-1:0]};
  assign push_rec      = '{last: s_axis_tlast, data: rec};
  assign keep_rec      = (rec != '0) | (DROP_ZERO == 0) | s_axis_tlast;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      ph_q <= PH_HI;
    end else begin
      ph_q <= ph_d;
    end
  end

  always_comb begin
    ph_d     = ph_q;
    push     = 1'b0;
    skip     = 1'b0;
    odd      = 1'b0;
    latch_hi = 1'b0;
    if (hs && keep_ok) begin
      unique case (ph_q)
        PH_HI: begin
          if (s_axis_tlast) begin
            odd = 1'b1;
          end else begin
            latch_hi = 1'b1;
            ph_d     = PH_LO;
          end
        end
        PH_LO: begin
          ph_d = PH_HI;
          push = keep_rec;
          skip = ~keep_rec;
        end
        default: ph_d = PH_HI;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      rdy_q     <= 1'b0;
      hi_q      <= '0;
      rec_cnt   <= '0;
      skip_cnt  <= '0;
      frame_irq <= 1'b0;
      err_odd   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      frame_irq <= hs & s_axis_tlast;
      if (latch_hi) begin
        hi_q <= s_axis_tdata[HALF_W-1:0];
      end
      if (clr) begin
        rec_cnt  <= '0;
        skip_cnt <= '0;
        err_odd  <= 1'b0;
      end else begin
        if (push) begin
          rec_cnt <= sat_inc(rec_cnt);
        end
        if (skip) begin
          skip_cnt <= sat_inc(skip_cnt);
        end
        if (odd) begin
          err_odd <= 1'b1;
        end
      end
    end
  end

  match_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (s_axis_aclk),
    .rst    (s_axis_areset),
    .wr_en  (push),
    .wr_data(push_rec),
    .full   (full),
    .rd_en  (m_match_ready),
    .rd_data(head_bits),
    .empty  (empty)
  );

  assign head          = match_rec_t'(head_bits);
  assign m_match_data  = head.data;
  assign m_match_last  = head.last;
  assign m_match_valid = ~empty;

endmodule

// File: tb/tb_axis_match_unpack.sv
// Self-checking bench for axis_match_unpack.
// Record-level reference model plus directed and random scenarios.
module tb_axis_match_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [39:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        clr;
  logic [15:0] rec_cnt;
  logic [15:0] skip_cnt;
  logic        frame_irq;
  logic        err_odd;

  always #5 clk = ~clk;

  axis_match_unpack #(
    .FIFO_DEPTH(16),
    .DROP_ZERO (1)
  ) dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(rst),
    .s_axis_tdata (tdata),
    .s_axis_tkeep (tkeep),
    .s_axis_tlast (tlast),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .m_match_data (m_data),
    .m_match_last (m_last),
    .m_match_valid(m_valid),
    .m_match_ready(m_ready),
    .clr          (clr),
    .rec_cnt      (rec_cnt),
    .skip_cnt     (skip_cnt),
    .frame_irq    (frame_irq),
    .err_odd      (err_odd)
  );

  int          n_total = 0;
  int          n_fail  = 0;
  logic [40:0] exp_q[$];
  logic [40:0] obs_q[$];
  logic [15:0] m_rec;
  logic [15:0] m_skip;
  logic        m_err;
  logic        m_have;
  logic [19:0] m_hi;
  logic        irq_seen;

  task automatic model_clr();
    m_rec  = '0;
    m_skip = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_clr();
    m_have = 1'b0;
    m_hi   = '0;
  endtask

  // Reference: a record is two full beats; zero records vanish unless framed.
  task automatic model_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l);
    logic [39:0] r;
    if (k != 4'hf) return;
    if (!m_have) begin
      if (l) m_err = 1'b1;
      else begin
        m_hi   = d[19:0];
        m_have = 1'b1;
      end
    end else begin
      m_have = 1'b0;
      r = {m_hi, d[19:0]};
      if (r != 40'd0 || l) begin
        exp_q.push_back({l, r});
        if (m_rec != 16'hffff) m_rec = m_rec + 16'd1;
      end else if (m_skip != 16'hffff) begin
        m_skip = m_skip + 16'd1;
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l);
    bit ok = 1'b0;
    int i  = 0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    while (!ok && i < 200) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      i++;
    end
    #1;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    irq_seen = frame_irq;
    if (ok) model_beat(d, k, l);
    else begin
      n_total++;
      n_fail++;
      $display("FAIL send_timeout: tready=0 for 200 cycles, required 1");
    end
  endtask

  task automatic send_pair(input logic [19:0] h, input logic [19:0] lo,
                           input logic l);
    send_beat({12'($urandom), h}, 4'hf, 1'b0);
    send_beat({12'($urandom), lo}, 4'hf, l);
  endtask

  task automatic pop_n(input int n);
    obs_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 600 && obs_q.size() < n; i++) begin
      @(negedge clk);
      if (m_valid) obs_q.push_back({m_last, m_data});
      @(posedge clk);
    end
    #1 m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clr();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({tready, m_valid, m_data, m_last} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_out: tready=%b valid=%b data=%h last=%b, required 0",
               tready, m_valid, m_data, m_last);
    end
    n_total++;
    if ({rec_cnt, skip_cnt, frame_irq, err_odd} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_stat: rec=%0d skip=%0d irq=%b err=%b, required 0",
               rec_cnt, skip_cnt, frame_irq, err_odd);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel: tready=%b, required 0 before first edge", tready);
    end
    @(posedge clk);
    #1;
    n_total++;
    if (tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: tready=%b, required 1", tready);
    end
    model_reset();
  endtask

  task automatic test_basic();
    pulse_clr();
    send_beat(32'h0001_2345, 4'hf, 1'b0);
    send_beat(32'h000A_BCDE, 4'hf, 1'b1);
    n_total++;
    if (irq_seen !== 1'b1 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_lat: irq=%b valid=%b, required 1 1", irq_seen, m_valid);
    end
    @(posedge clk);
    #1;
    n_total++;
    if (frame_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse: irq=%b, required 0", frame_irq);
    end
    n_total++;
    if (rec_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_cnt: rec_cnt=%0d, required 1", rec_cnt);
    end
    pop_n(1);
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 40'h12345_ABCDE}) begin
      n_fail++;
      $display("FAIL basic_rec: got %0d recs head=%h, required 1 recs %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 41'd0,
               {1'b1, 40'h12345_ABCDE});
    end
    exp_q.delete();
  endtask

  task automatic test_zero();
    pulse_clr();
    repeat (4) send_beat(32'h0, 4'hf, 1'b0);
    send_beat(32'h0, 4'hf, 1'b0);
    send_beat(32'h0, 4'hf, 1'b1);
    n_total++;
    if (skip_cnt !== m_skip || rec_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_cnt: skip=%0d rec=%0d, required %0d 1",
               skip_cnt, rec_cnt, m_skip);
    end
    pop_n(1);
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 40'd0} || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rec: got %0d recs valid_after=%b, required one %h",
               obs_q.size(), m_valid, {1'b1, 40'd0});
    end
    exp_q.delete();
  endtask

  task automatic test_keep();
    pulse_clr();
    send_beat(32'h0005_4321, 4'hf, 1'b0);
    send_beat($urandom, 4'h3, 1'b0);
    send_beat(32'h0009_8765, 4'hf, 1'b0);
    send_beat($urandom, 4'h1, 1'b1);
    n_total++;
    if (irq_seen !== 1'b1 || rec_cnt !== 16'd1 || err_odd !== 1'b0) begin
      n_fail++;
      $display("FAIL keep_side: irq=%b rec=%0d err=%b, required 1 1 0",
               irq_seen, rec_cnt, err_odd);
    end
    pop_n(exp_q.size());
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 40'h54321_98765}) begin
      n_fail++;
      $display("FAIL keep_rec: got %0d recs, required %h", obs_q.size(),
               {1'b0, 40'h54321_98765});
    end
    exp_q.delete();
  endtask

  task automatic test_odd();
    pulse_clr();
    send_pair(20'h11111, 20'h22222, 1'b0);
    send_beat(32'h0003_3333, 4'hf, 1'b1);
    n_total++;
    if (irq_seen !== 1'b1 || err_odd !== 1'b1 || rec_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL odd_flag: irq=%b err=%b rec=%0d, required 1 1 1",
               irq_seen, err_odd, rec_cnt);
    end
    send_pair(20'h44444, 20'h55555, 1'b1);
    pop_n(exp_q.size());
    n_total++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL odd_count: got %0d recs, required %0d",
               obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        n_total++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL odd_rec[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
    pulse_clr();
    n_total++;
    if (err_odd !== 1'b0 || rec_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL odd_clr: err=%b rec=%0d, required 0 0", err_odd, rec_cnt);
    end
  endtask

  task automatic test_clr_priority();
    pulse_clr();
    send_beat(32'h000F_0F0F, 4'hf, 1'b0);
    clr = 1'b1;
    send_beat(32'h0000_0F0F, 4'hf, 1'b0);
    clr = 1'b0;
    model_clr();
    n_total++;
    if (rec_cnt !== m_rec || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_prio: rec=%0d valid=%b, required %0d 1",
               rec_cnt, m_valid, m_rec);
    end
    pop_n(1);
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL clr_rec: got %0d recs, required %h", obs_q.size(), exp_q[0]);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [19:0] hv[20];
    logic [19:0] lv[20];
    pulse_clr();
    m_ready = 1'b0;
    foreach (hv[i]) begin
      hv[i] = 20'($urandom_range(1, 20'hfffff));
      lv[i] = 20'($urandom);
    end
    for (int i = 0; i < 16; i++) send_pair(hv[i], lv[i], 1'b0);
    send_beat({12'h0, hv[16]}, 4'hf, 1'b0);
    @(negedge clk);
    n_total++;
    if (tready !== 1'b0 || m_valid !== 1'b1 || rec_cnt !== 16'd16) begin
      n_fail++;
      $display("FAIL bp_full: tready=%b valid=%b rec=%0d, required 0 1 16",
               tready, m_valid, rec_cnt);
    end
    @(posedge clk);
    #1;
    fork
      begin
        send_beat({12'h0, lv[16]}, 4'hf, 1'b0);
        for (int i = 17; i < 20; i++) send_pair(hv[i], lv[i], i == 19);
      end
      begin
        repeat (3) @(posedge clk);
        #1 pop_n(20);
      end
    join
    n_total++;
    if (obs_q.size() != exp_q.size() || rec_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL bp_count: got %0d recs rec=%0d, required %0d 20",
               obs_q.size(), rec_cnt, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        n_total++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bp_rec[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    pulse_clr();
    for (int i = 0; i < 24; i++) begin
      d = ($urandom_range(0, 2) == 0) ? {12'($urandom), 20'h0} : $urandom;
      k = ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hf;
      l = $urandom_range(0, 5) == 0;
      send_beat(d, k, l);
      n_total++;
      if (irq_seen !== l) begin
        n_fail++;
        $display("FAIL rnd_irq[%0d]: irq=%b, required %b", i, irq_seen, l);
      end
    end
    n_total++;
    if (rec_cnt !== m_rec || skip_cnt !== m_skip || err_odd !== m_err) begin
      n_fail++;
      $display("FAIL rnd_stat: rec=%0d skip=%0d err=%b, required %0d %0d %b",
               rec_cnt, skip_cnt, err_odd, m_rec, m_skip, m_err);
    end
    pop_n(exp_q.size());
    n_total++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d recs, required %0d",
               obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        n_total++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd_rec[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pair(20'($urandom_range(1, 20'hfffff)),
                                          20'($urandom), 1'b0);
    send_beat(32'h000A_AAAA, 4'hf, 1'b0);
    n_total++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%b, required 1", m_valid);
    end
    rst = 1'b1;
    #1;
    n_total++;
    if ({tready, m_valid, m_data, m_last, rec_cnt, skip_cnt, frame_irq, err_odd}
        !== 77'd0) begin
      n_fail++;
      $display("FAIL mid_rst: tready=%b valid=%b data=%h rec=%0d, required 0",
               tready, m_valid, m_data, rec_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_pair(20'h0BEEF, 20'h0CAFE, 1'b1);
    pop_n(exp_q.size());
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 40'h0BEEF_0CAFE} ||
        rec_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_fresh: got %0d recs rec=%0d, required %h rec=1",
               obs_q.size(), rec_cnt, {1'b1, 40'h0BEEF_0CAFE});
    end
    exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    tdata   = '0;
    tkeep   = '0;
    tlast   = 1'b0;
    tvalid  = 1'b0;
    m_ready = 1'b0;
    clr     = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_zero();
    test_keep();
    test_odd();
    test_clr_priority();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
